// File: rtl/result_serializer.sv
// Parallel-to-serial result stage: a hold bank and a shift bank stream LANES results per word, lane 0 first.
// Optional macro SERIALIZER_RELU_EN clamps negative results to zero on the output mux.
module result_serializer #(
  parameter int LANES = 28,
  parameter int DW    = 20,
  parameter int COLS  = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [LANES*DW-1:0]   para_res_i,
  output logic [DW-1:0]         res_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  full_o,
  output logic                  frame_done_o,
  output logic                  ovf_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state, w_state_nxt;
  logic signed [DW-1:0]  r_hold  [LANES];
  logic signed [DW-1:0]  r_shift [LANES];
  logic                  r_full, r_ovf, r_fdone;
  logic [LW-1:0]         r_lane, w_lane_nxt;
  logic [CW-1:0]         r_col, w_col_nxt;
  logic                  w_accept, w_last, w_reload, w_load_ok, w_fdone_nxt;

  function automatic logic signed [DW-1:0] relu_clamp(input logic signed [DW-1:0] x);
`ifdef SERIALIZER_RELU_EN
    return x[DW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  assign w_accept  = (r_state == S_STREAM) && ready_i;
  assign w_last    = (r_lane == LAST_LANE);
  // A draining hold bank can take a new word in the same edge without overflow.
  assign w_load_ok = load_i && (!r_full || w_reload);

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_col_nxt   = r_col;
    w_reload    = 1'b0;
    w_fdone_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full) begin
          w_state_nxt = S_STREAM;
          w_reload    = 1'b1;
          w_lane_nxt  = '0;
        end
      end
      S_STREAM: begin
        if (w_accept) begin
          if (w_last) begin
            w_lane_nxt  = '0;
            w_fdone_nxt = (r_col == LAST_COL);
            w_col_nxt   = (r_col == LAST_COL) ? '0 : r_col + 1'b1;
            if (r_full) w_reload    = 1'b1;
            else        w_state_nxt = S_IDLE;
          end else begin
            w_lane_nxt = r_lane + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lane  <= '0;
      r_col   <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_col   <= w_col_nxt;
      r_fdone <= w_fdone_nxt;
      if (w_load_ok)     r_full <= 1'b1;
      else if (w_reload) r_full <= 1'b0;
      if (load_i && !w_load_ok) r_ovf <= 1'b1;
    end
  end

  // Data banks are cleared on reset so a mid-stream reset discards buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) begin
        r_hold[k]  <= '0;
        r_shift[k] <= '0;
      end
    end else begin
      if (w_reload) r_shift <= r_hold;
      if (w_load_ok) begin
        for (int k = 0; k < LANES; k++) r_hold[k] <= para_res_i[k*DW +: DW];
      end
    end
  end

  assign valid_o      = (r_state == S_STREAM);
  assign res_o        = valid_o ? relu_clamp(r_shift[r_lane]) : '0;
  assign full_o       = r_full;
  assign frame_done_o = r_fdone;
  assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: latency, frame pacing, overflow, backpressure and async reset.
module tb_result_serializer;
  localparam int LANES = 28;
  localparam int DW    = 20;
  localparam int COLS  = 28;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load_i = 1'b0;
  logic [LANES*DW-1:0] para_res_i = '0;
  logic [DW-1:0]       res_o;
  logic                valid_o;
  logic                ready_i = 1'b0;
  logic                full_o;
  logic                frame_done_o;
  logic                ovf_o;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wv [LANES];

  result_serializer #(.LANES(LANES), .DW(DW), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .para_res_i(para_res_i),
    .res_o(res_o), .valid_o(valid_o), .ready_i(ready_i), .full_o(full_o),
    .frame_done_o(frame_done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Score any accepted result against the expected stream, then advance one clock.
  task automatic cyc();
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) chk("extra_valid", 32'(valid_o), 32'd0);
      else                   chk("res", 32'(res_o), 32'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_load(input bit expect_it);
    for (int k = 0; k < LANES; k++) begin
      para_res_i[k*DW +: DW] = wv[k];
      if (expect_it) exp_q.push_back(wv[k]);
    end
    load_i = 1'b1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    load_i  = 1'b0;
    ready_i = 1'b0;
    exp_q.delete();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // COLS words loaded every LANES cycles with ready high: no bubble, one frame_done pulse.
  task automatic frame_run();
    int fd_cnt = 0;
    int fd_e = -1;
    ready_i = 1'b1;
    for (int e = 0; e <= LANES*COLS + 2; e++) begin
      if (e % LANES == 0 && e / LANES < COLS) begin
        for (int k = 0; k < LANES; k++) wv[k] = DW'(((e / LANES) << 6) | k);
        drive_load(1'b1);
      end else begin
        load_i = 1'b0;
      end
      if (e >= 2 && e <= LANES*COLS + 1) chk("nobubble", 32'(valid_o), 32'd1);
      if (frame_done_o) begin
        fd_cnt++;
        fd_e = e;
      end
      cyc();
    end
    load_i = 1'b0;
    chk("frame_done_count", 32'(fd_cnt), 32'd1);
    chk("frame_done_cycle", 32'(fd_e), 32'(LANES*COLS + 2));
    chk("frame_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_idle", 32'(valid_o), 32'd0);
    chk("frame_no_ovf", 32'(ovf_o), 32'd0);
  endtask

  initial begin
    logic          prev_hold;
    logic [DW-1:0] prev_res;
    logic [DW-1:0] neg_exp;

    // Reset state
    apply_reset();
    chk("rst_res", 32'(res_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_fdone", 32'(frame_done_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);

    // Single word, lane k = k+1
    ready_i = 1'b1;
    for (int k = 0; k < LANES; k++) wv[k] = DW'(k + 1);
    drive_load(1'b1);
    cyc();
    load_i = 1'b0;
    chk("t1_full", 32'(full_o), 32'd1);
    chk("t1_valid_early", 32'(valid_o), 32'd0);
    cyc();
    chk("t1_valid", 32'(valid_o), 32'd1);
    chk("t1_lane0", 32'(res_o), 32'd1);
    chk("t1_full_clear", 32'(full_o), 32'd0);
    for (int i = 0; i < LANES; i++) cyc();
    chk("t1_valid_end", 32'(valid_o), 32'd0);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Full frame
    apply_reset();
    frame_run();

    // Overflow: third word arrives while the hold bank is occupied
    apply_reset();
    ready_i = 1'b1;
    for (int k = 0; k < LANES; k++) wv[k] = DW'(12'h100 + k);
    drive_load(1'b1);
    cyc();
    load_i = 1'b0;
    cyc();
    for (int k = 0; k < LANES; k++) wv[k] = DW'(12'h200 + k);
    drive_load(1'b1);
    cyc();
    chk("t3_full", 32'(full_o), 32'd1);
    chk("t3_no_ovf_yet", 32'(ovf_o), 32'd0);
    for (int k = 0; k < LANES; k++) wv[k] = DW'(12'h300 + k);
    drive_load(1'b0);
    cyc();
    load_i = 1'b0;
    chk("t3_ovf", 32'(ovf_o), 32'd1);
    for (int i = 0; i < 3*LANES; i++) cyc();
    chk("t3_ovf_sticky", 32'(ovf_o), 32'd1);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    chk("t3_idle", 32'(valid_o), 32'd0);

    // Backpressure with a negative lane
`ifdef SERIALIZER_RELU_EN
    neg_exp = '0;
`else
    neg_exp = 20'hFFFFD;
`endif
    apply_reset();
    for (int k = 0; k < LANES; k++) wv[k] = DW'(k + 1);
    wv[5] = 20'hFFFFD;
    drive_load(1'b0);
    for (int k = 0; k < LANES; k++) exp_q.push_back((k == 5) ? neg_exp : DW'(k + 1));
    prev_hold = 1'b0;
    prev_res  = '0;
    for (int e = 0; e < 4*LANES; e++) begin
      if (e > 0) load_i = 1'b0;
      ready_i = (e % 2 == 0);
      if (prev_hold) chk("t4_hold", 32'(res_o), 32'(prev_res));
      prev_hold = valid_o && !ready_i;
      prev_res  = res_o;
      cyc();
    end
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // Async reset at lane 10 of word 3 with the hold bank full
    apply_reset();
    ready_i = 1'b1;
    for (int e = 0; e <= 3*LANES + 11; e++) begin
      if (e % LANES == 0 && e / LANES <= 3) begin
        for (int k = 0; k < LANES; k++) wv[k] = DW'(((e / LANES) << 8) | k);
        drive_load(1'b1);
      end else if (e == 3*LANES + 5) begin
        for (int k = 0; k < LANES; k++) wv[k] = DW'(12'hF00 | k);
        drive_load(1'b1);
      end else begin
        load_i = 1'b0;
      end
      cyc();
    end
    load_i = 1'b0;
    chk("t5_pre_valid", 32'(valid_o), 32'd1);
    chk("t5_pre_lane10", 32'(res_o), 32'((3 << 8) | 10));
    chk("t5_pre_full", 32'(full_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(valid_o), 32'd0);
    chk("t5_rst_res", 32'(res_o), 32'd0);
    chk("t5_rst_full", 32'(full_o), 32'd0);
    chk("t5_rst_fdone", 32'(frame_done_o), 32'd0);
    apply_reset();
    frame_run();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
